neighbor_table_ctrl: RTL and testbench

NEIGHBOR_TABLE_CTRL -- requirements
Module: neighbor_table_ctrl

---
 rtl/neighbor_table_ctrl_pkg.sv | 16 +
 rtl/neighbor_table_ctrl.sv | 165 ++++++++++++++++
 tb/tb_neighbor_table_ctrl.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/neighbor_table_ctrl_pkg.sv
// Shared definitions for the neighbor table controller: FSM states and table geometry.
package neighbor_table_ctrl_pkg;

  localparam int TBL_DEPTH = 32;
  localparam int IDX_W     = 5;
  localparam int CNT_W     = IDX_W + 1;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    WRITE,
    READ,
    CLEAR
  } state_e;

endpackage

// File: rtl/neighbor_table_ctrl.sv
// Arbitrates insert/update writes, indexed reads and heartbeat clears for an
// external neighbor table, tracking per-entry valid bits and the live entry count.
module neighbor_table_ctrl
  import neighbor_table_ctrl_pkg::*;
#(
  parameter int                    WORD_WIDTH = 16,
  parameter int                    TBL_DEPTH  = neighbor_table_ctrl_pkg::TBL_DEPTH,
  parameter logic [WORD_WIDTH-1:0] MY_NODE_ID = 16'h000C
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_req,
  input  logic [WORD_WIDTH-1:0] wr_node_id,
  input  logic                  rd_req,
  input  logic [IDX_W-1:0]      rd_idx,
  input  logic                  hb_reset,
  input  logic [WORD_WIDTH-1:0] tbl_rd_node_id,
  output logic [IDX_W-1:0]      tbl_idx,
  output logic                  tbl_wr_en,
  output logic                  wr_ack,
  output logic                  wr_drop,
  output logic                  rd_ack,
  output logic [TBL_DEPTH-1:0]  valid_vec,
  output logic [CNT_W-1:0]      neighbor_count,
  output logic                  busy
);

  localparam logic [CNT_W-1:0] L_FULL_CNT = CNT_W'(TBL_DEPTH);

  state_e                r_state;
  state_e                w_state_nxt;
  logic [IDX_W-1:0]      r_idx;
  logic [IDX_W-1:0]      w_idx_nxt;
  logic [WORD_WIDTH-1:0] r_wr_id;
  logic                  r_alloc;
  logic                  w_alloc_nxt;
  logic                  r_drop;
  logic                  w_drop_nxt;
  logic                  w_latch_id;
  logic                  r_hb_pend;
  logic [TBL_DEPTH-1:0]  r_valid_vec;
  logic [CNT_W-1:0]      r_count;

  logic w_hb;
  logic w_wr_take;
  logic w_scan_last;
  logic w_full;

  // A request is still high during its own drop pulse, so it is not re-sampled then.
  assign w_hb        = hb_reset | r_hb_pend;
  assign w_wr_take   = wr_req & ~r_drop;
  assign w_scan_last = ({1'b0, r_idx} == (r_count - CNT_W'(1)));
  assign w_full      = (r_count >= L_FULL_CNT);

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_alloc_nxt = r_alloc;
    w_drop_nxt  = 1'b0;
    w_latch_id  = 1'b0;
    tbl_wr_en   = 1'b0;
    wr_ack      = 1'b0;
    rd_ack      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_hb) begin
          w_state_nxt = CLEAR;
        end else if (w_wr_take) begin
          if (wr_node_id == MY_NODE_ID) begin
            w_drop_nxt = 1'b1;
          end else begin
            w_latch_id = 1'b1;
            w_idx_nxt  = '0;
            if (r_count == '0) begin
              w_state_nxt = WRITE;
              w_alloc_nxt = 1'b1;
            end else begin
              w_state_nxt = SCAN;
              w_alloc_nxt = 1'b0;
            end
          end
        end else if (rd_req) begin
          w_state_nxt = READ;
          w_idx_nxt   = rd_idx;
        end
      end
      SCAN: begin
        // An allocation spends one extra SCAN cycle presenting the fresh index before the strobe.
        if (r_alloc) begin
          w_state_nxt = WRITE;
        end else if (tbl_rd_node_id == r_wr_id) begin
          w_state_nxt = WRITE;
        end else if (w_scan_last) begin
          if (w_full) begin
            w_drop_nxt  = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_idx_nxt   = r_count[IDX_W-1:0];
            w_alloc_nxt = 1'b1;
          end
        end else begin
          w_idx_nxt = r_idx + IDX_W'(1);
        end
      end
      WRITE: begin
        tbl_wr_en   = 1'b1;
        wr_ack      = 1'b1;
        w_state_nxt = IDLE;
      end
      READ: begin
        rd_ack      = 1'b1;
        w_state_nxt = IDLE;
      end
      CLEAR: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_wr_id     <= '0;
      r_alloc     <= 1'b0;
      r_drop      <= 1'b0;
      r_hb_pend   <= 1'b0;
      r_valid_vec <= '0;
      r_count     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_alloc <= w_alloc_nxt;
      r_drop  <= w_drop_nxt;
      if (w_latch_id) begin
        r_wr_id <= wr_node_id;
      end
      // A heartbeat seen while busy waits here until the FSM is back in IDLE.
      if (r_state == IDLE) begin
        r_hb_pend <= 1'b0;
      end else if (hb_reset) begin
        r_hb_pend <= 1'b1;
      end
      if (r_state == CLEAR) begin
        r_valid_vec <= '0;
        r_count     <= '0;
      end else if (r_state == WRITE) begin
        r_valid_vec[r_idx] <= 1'b1;
        if (r_alloc) begin
          r_count <= r_count + CNT_W'(1);
        end
      end
    end
  end

  assign tbl_idx        = r_idx;
  assign wr_drop        = r_drop;
  assign valid_vec      = r_valid_vec;
  assign neighbor_count = r_count;
  assign busy           = (r_state != IDLE);

endmodule

// File: tb/tb_neighbor_table_ctrl.sv
// Directed bench for neighbor_table_ctrl with a behavioral external table model.
module tb_neighbor_table_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_req = 1'b0;
  logic [15:0] wr_node_id = '0;
  logic        rd_req = 1'b0;
  logic [4:0]  rd_idx = '0;
  logic        hb_reset = 1'b0;
  logic [15:0] tbl_rd_node_id;
  logic [4:0]  tbl_idx;
  logic        tbl_wr_en;
  logic        wr_ack;
  logic        wr_drop;
  logic        rd_ack;
  logic [31:0] valid_vec;
  logic [5:0]  neighbor_count;
  logic        busy;

  int testsRun = 0;
  int failCount = 0;

  typedef struct {
    logic [15:0] id;
    logic        expDrop;
    int          expLat;
    logic [4:0]  expIdx;
    logic [5:0]  expCount;
    logic [31:0] expVec;
  } wrVec_t;

  wrVec_t vecs [7];

  logic [15:0] tblMem [32];

  neighbor_table_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .wr_req         (wr_req),
    .wr_node_id     (wr_node_id),
    .rd_req         (rd_req),
    .rd_idx         (rd_idx),
    .hb_reset       (hb_reset),
    .tbl_rd_node_id (tbl_rd_node_id),
    .tbl_idx        (tbl_idx),
    .tbl_wr_en      (tbl_wr_en),
    .wr_ack         (wr_ack),
    .wr_drop        (wr_drop),
    .rd_ack         (rd_ack),
    .valid_vec      (valid_vec),
    .neighbor_count (neighbor_count),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  assign tbl_rd_node_id = tblMem[tbl_idx];

  always @(posedge clk) begin
    if (tbl_wr_en) tblMem[tbl_idx] <= wr_node_id;
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input wrVec_t v);
    int         lat;
    logic       gotAck;
    logic       gotDrop;
    logic       sawWrEn;
    logic [4:0] idxAtAck;
    lat = 0; gotAck = 1'b0; gotDrop = 1'b0; sawWrEn = 1'b0; idxAtAck = '0;
    wr_node_id = v.id;
    wr_req = 1'b1;
    while (!gotAck && !gotDrop && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (tbl_wr_en) sawWrEn = 1'b1;
      if (wr_ack) begin
        gotAck = 1'b1;
        idxAtAck = tbl_idx;
      end
      if (wr_drop) gotDrop = 1'b1;
    end
    wr_req = 1'b0;
    checkOutput("wr_drop", 64'(gotDrop), 64'(v.expDrop));
    checkOutput("wr_ack", 64'(gotAck), 64'(!v.expDrop));
    checkOutput("wr_latency", 64'(lat), 64'(v.expLat));
    checkOutput("tbl_wr_en_seen", 64'(sawWrEn), 64'(!v.expDrop));
    if (!v.expDrop) checkOutput("wr_idx", 64'(idxAtAck), 64'(v.expIdx));
    @(posedge clk); #1;
    checkOutput("neighbor_count", 64'(neighbor_count), 64'(v.expCount));
    checkOutput("valid_vec", 64'(valid_vec), 64'(v.expVec));
    checkOutput("busy_after_wr", 64'(busy), 64'(0));
  endtask

  task automatic readTxn(input logic [4:0] idx);
    int         lat;
    logic       got;
    logic [4:0] idxAtAck;
    lat = 0; got = 1'b0; idxAtAck = '0;
    rd_idx = idx;
    rd_req = 1'b1;
    while (!got && lat < 10) begin
      @(posedge clk); #1;
      lat++;
      if (rd_ack) begin
        got = 1'b1;
        idxAtAck = tbl_idx;
      end
    end
    rd_req = 1'b0;
    checkOutput("rd_latency", 64'(lat), 64'(1));
    checkOutput("rd_idx_presented", 64'(idxAtAck), 64'(idx));
    @(posedge clk); #1;
  endtask

  initial begin
    int          lat;
    logic        got;
    logic        sawBad;
    logic [4:0]  idxv;
    logic [5:0]  modelCount;
    logic [31:0] modelVec;
    wrVec_t      v;

    vecs[0] = '{16'h0005, 1'b0, 1, 5'd0, 6'd1, 32'h0000_0001};
    vecs[1] = '{16'h0007, 1'b0, 3, 5'd1, 6'd2, 32'h0000_0003};
    vecs[2] = '{16'h0007, 1'b0, 3, 5'd1, 6'd2, 32'h0000_0003};
    vecs[3] = '{16'h000C, 1'b1, 1, 5'd0, 6'd2, 32'h0000_0003};
    vecs[4] = '{16'h0005, 1'b0, 2, 5'd0, 6'd2, 32'h0000_0003};
    vecs[5] = '{16'h0009, 1'b0, 4, 5'd2, 6'd3, 32'h0000_0007};
    vecs[6] = '{16'h0009, 1'b0, 4, 5'd2, 6'd3, 32'h0000_0007};

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_busy", 64'(busy), 64'(0));
    checkOutput("rst_count", 64'(neighbor_count), 64'(0));
    checkOutput("rst_valid_vec", 64'(valid_vec), 64'(0));
    checkOutput("rst_tbl_idx", 64'(tbl_idx), 64'(0));
    checkOutput("rst_strobes", 64'({tbl_wr_en, wr_ack, wr_drop, rd_ack}), 64'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) applyStimulus(vecs[i]);

    // Fill the table with fresh IDs; each allocation scans all live entries first.
    modelCount = 6'd3;
    modelVec   = 32'h0000_0007;
    for (int i = 3; i < 32; i++) begin
      v.id       = 16'h0100 + 16'(i);
      v.expDrop  = 1'b0;
      v.expLat   = int'(modelCount) + 2;
      v.expIdx   = modelCount[4:0];
      modelVec   = modelVec | (32'h1 << i);
      modelCount = modelCount + 6'd1;
      v.expCount = modelCount;
      v.expVec   = modelVec;
      applyStimulus(v);
    end

    v = '{16'h0FFF, 1'b1, 33, 5'd0, 6'd32, 32'hFFFF_FFFF};
    applyStimulus(v);
    v = '{16'h011F, 1'b0, 33, 5'd31, 6'd32, 32'hFFFF_FFFF};
    applyStimulus(v);

    readTxn(5'd5);

    // Heartbeat arrives mid-scan: the update finishes, then the table is cleared.
    wr_node_id = 16'h0009;
    wr_req = 1'b1;
    @(posedge clk); #1;
    hb_reset = 1'b1;
    @(posedge clk); #1;
    hb_reset = 1'b0;
    lat = 2; got = 1'b0; idxv = '0;
    while (!got && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (wr_ack) begin
        got = 1'b1;
        idxv = tbl_idx;
      end
    end
    wr_req = 1'b0;
    checkOutput("hb_scan_latency", 64'(lat), 64'(4));
    checkOutput("hb_scan_idx", 64'(idxv), 64'(2));
    @(posedge clk); #1;
    checkOutput("hb_count_before_clear", 64'(neighbor_count), 64'(32));
    @(posedge clk); #1;
    checkOutput("hb_busy_in_clear", 64'(busy), 64'(1));
    @(posedge clk); #1;
    checkOutput("hb_count_cleared", 64'(neighbor_count), 64'(0));
    checkOutput("hb_valid_cleared", 64'(valid_vec), 64'(0));
    checkOutput("hb_busy_idle", 64'(busy), 64'(0));

    // Simultaneous write and read: the write wins, the read follows.
    wr_node_id = 16'h0005;
    wr_req = 1'b1;
    rd_idx = 5'd7;
    rd_req = 1'b1;
    @(posedge clk); #1;
    checkOutput("both_wr_ack", 64'(wr_ack), 64'(1));
    checkOutput("both_rd_not_first", 64'(rd_ack), 64'(0));
    checkOutput("both_wr_idx", 64'(tbl_idx), 64'(0));
    wr_req = 1'b0;
    lat = 1; got = 1'b0; idxv = '0;
    while (!got && lat < 10) begin
      @(posedge clk); #1;
      lat++;
      if (rd_ack) begin
        got = 1'b1;
        idxv = tbl_idx;
      end
    end
    rd_req = 1'b0;
    checkOutput("both_rd_latency", 64'(lat), 64'(3));
    checkOutput("both_rd_idx", 64'(idxv), 64'(7));
    @(posedge clk); #1;
    checkOutput("both_count", 64'(neighbor_count), 64'(1));

    readTxn(5'd20);

    // Reset in the middle of an allocation scan aborts without any strobe.
    wr_node_id = 16'h0006;
    wr_req = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checkOutput("midrst_busy", 64'(busy), 64'(0));
    checkOutput("midrst_count", 64'(neighbor_count), 64'(0));
    checkOutput("midrst_valid", 64'(valid_vec), 64'(0));
    wr_req = 1'b0;
    sawBad = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (tbl_wr_en || wr_ack || wr_drop) sawBad = 1'b1;
    end
    checkOutput("midrst_no_strobe", 64'(sawBad), 64'(0));
    checkOutput("midrst_count_after", 64'(neighbor_count), 64'(0));

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
